// File: rtl/cp0_exception_if.sv
// Commit-stage <-> CP0 bundle: per-instruction exception events, MTC0/MFC0
// access, and the flush/redirect plus register-view outputs.
interface cp0_exception_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  inst_valid;
    logic [31:0]           pc;
    logic                  in_delay_slot;
    logic                  if_addr_err;
    logic                  mem_addr_err;
    logic                  mem_is_store;
    logic [31:0]           bad_addr;
    logic                  reserved_inst;
    logic                  overflow_err;
    logic                  syscall;
    logic                  break_inst;
    logic                  eret;
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  cp0_wen;
    logic [4:0]            cp0_waddr;
    logic [31:0]           cp0_wdata;
    logic [4:0]            cp0_raddr;
    logic [31:0]           cp0_rdata;
    logic                  exc_flush;
    logic [31:0]           exc_new_pc;
    logic [31:0]           status_out;
    logic [31:0]           cause_out;
    logic [31:0]           epc_out;
    logic                  timer_int;

    modport master (
        output inst_valid, pc, in_delay_slot, if_addr_err, mem_addr_err, mem_is_store,
               bad_addr, reserved_inst, overflow_err, syscall, break_inst, eret, hw_int,
               cp0_wen, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, exc_flush, exc_new_pc, status_out, cause_out, epc_out, timer_int
    );

    modport slave (
        input  inst_valid, pc, in_delay_slot, if_addr_err, mem_addr_err, mem_is_store,
               bad_addr, reserved_inst, overflow_err, syscall, break_inst, eret, hw_int,
               cp0_wen, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, exc_flush, exc_new_pc, status_out, cause_out, epc_out, timer_int
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt unit: owns BadVAddr/Count/Compare/Status/Cause/EPC,
// prioritises commit-stage exceptions, handles ERET and the Count/Compare timer.
module cp0_exception_unit #(
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic           clk,
    input  logic           rst,
    cp0_exception_if.slave bus
);
    localparam int               DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [31:0]           badvaddr_q, badvaddr_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           epc_q, epc_d;
    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic                  ti_q, ti_d;
    logic [NUM_HW_INT-1:0] ip_hw_q, ip_hw_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [DIV_W-1:0]      div_q, div_d;

    logic [7:0]  ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] rdata;
    logic        int_req;
    logic        take_exc;
    logic        take_eret;
    logic        bad_fetch;
    logic        bad_data;
    logic        cp0_wr;
    logic [4:0]  exc_code;

    // IP[7] doubles as the timer interrupt line on top of the last hardware input
    always_comb begin
        ip                  = '0;
        ip[1:0]             = ip_sw_q;
        ip[2 +: NUM_HW_INT] = ip_hw_q;
        ip[7]               = ip[7] | ti_q;
    end

    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

    always_comb begin
        take_exc  = 1'b0;
        exc_code  = EXC_INT;
        bad_fetch = 1'b0;
        bad_data  = 1'b0;
        int_req   = bus.inst_valid & ie_q & ~exl_q & (|(ip & im_q));
        if (int_req) begin
            take_exc = 1'b1;
        end else if (bus.inst_valid) begin
            take_exc = 1'b1;
            if (bus.if_addr_err) begin
                exc_code  = EXC_ADEL;
                bad_fetch = 1'b1;
            end else if (bus.reserved_inst) begin
                exc_code = EXC_RI;
            end else if (bus.overflow_err) begin
                exc_code = EXC_OV;
            end else if (bus.syscall) begin
                exc_code = EXC_SYS;
            end else if (bus.break_inst) begin
                exc_code = EXC_BP;
            end else if (bus.mem_addr_err) begin
                exc_code = bus.mem_is_store ? EXC_ADES : EXC_ADEL;
                bad_data = 1'b1;
            end else begin
                take_exc = 1'b0;
            end
        end
        take_eret = bus.inst_valid & bus.eret & ~take_exc;
        cp0_wr    = bus.cp0_wen & ~take_exc;
    end

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_hw_d    = bus.hw_int;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        div_d      = div_q + DIV_W'(1);

        if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
            if (count_q + 32'd1 == compare_q) begin
                ti_d = 1'b1;
            end
        end

        // A software write to Count replaces this cycle's tick entirely, TI included
        if (cp0_wr) begin
            case (bus.cp0_waddr)
                ADDR_COUNT: begin
                    count_d = bus.cp0_wdata;
                    div_d   = '0;
                    ti_d    = ti_q;
                end
                ADDR_COMPARE: begin
                    compare_d = bus.cp0_wdata;
                    ti_d      = 1'b0;
                end
                ADDR_STATUS: begin
                    im_d  = bus.cp0_wdata[15:8];
                    exl_d = bus.cp0_wdata[1];
                    ie_d  = bus.cp0_wdata[0];
                end
                ADDR_CAUSE: ip_sw_d = bus.cp0_wdata[9:8];
                ADDR_EPC:   epc_d   = bus.cp0_wdata;
                default: ;
            endcase
        end

        if (take_exc) begin
            exccode_d = exc_code;
            if (!exl_q) begin
                exl_d = 1'b1;
                bd_d  = bus.in_delay_slot;
                epc_d = bus.in_delay_slot ? (bus.pc - 32'd4) : bus.pc;
            end
            if (bad_fetch) begin
                badvaddr_d = bus.pc;
            end else if (bad_data) begin
                badvaddr_d = bus.bad_addr;
            end
        end else if (take_eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            div_q      <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            div_q      <= div_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.cp0_raddr)
            ADDR_BADVADDR: rdata = badvaddr_q;
            ADDR_COUNT:    rdata = count_q;
            ADDR_COMPARE:  rdata = compare_q;
            ADDR_STATUS:   rdata = status_val;
            ADDR_CAUSE:    rdata = cause_val;
            ADDR_EPC:      rdata = epc_q;
            default:       rdata = '0;
        endcase
    end

    assign bus.cp0_rdata  = rdata;
    assign bus.exc_flush  = ~rst & (take_exc | take_eret);
    assign bus.exc_new_pc = take_exc ? EXC_VECTOR : epc_q;
    assign bus.status_out = status_val;
    assign bus.cause_out  = cause_val;
    assign bus.epc_out    = epc_q;
    assign bus.timer_int  = ti_q;
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: directed commit-stage vectors push
// expected flush/register values; a negedge monitor pops and compares them.
module tb_cp0_exception_unit;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    localparam int EV_IFADDR = 1;
    localparam int EV_RI     = 2;
    localparam int EV_OV     = 4;
    localparam int EV_SYS    = 8;
    localparam int EV_BRK    = 16;
    localparam int EV_MEM    = 32;
    localparam int EV_STORE  = 64;
    localparam int EV_ERET   = 128;

    localparam int SRC_RD     = 0;
    localparam int SRC_CAUSE  = 1;
    localparam int SRC_EPC    = 2;
    localparam int SRC_STATUS = 3;
    localparam int SRC_TI     = 4;

    typedef struct {
        logic        flush;
        logic [31:0] pc;
        string       name;
    } flushExp_t;

    typedef struct {
        int          src;
        logic [31:0] exp;
        string       name;
    } readExp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic chkFlush = 1'b0;
    int   pendingReads = 0;

    flushExp_t flushQ[$];
    readExp_t  readQ[$];

    cp0_exception_if #(.NUM_HW_INT(6)) bus ();

    cp0_exception_unit #(
        .NUM_HW_INT(6),
        .EXC_VECTOR(VEC),
        .COUNT_DIV (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic clearPulses();
        bus.inst_valid    = 1'b0;
        bus.in_delay_slot = 1'b0;
        bus.if_addr_err   = 1'b0;
        bus.mem_addr_err  = 1'b0;
        bus.mem_is_store  = 1'b0;
        bus.bad_addr      = '0;
        bus.reserved_inst = 1'b0;
        bus.overflow_err  = 1'b0;
        bus.syscall       = 1'b0;
        bus.break_inst    = 1'b0;
        bus.eret          = 1'b0;
        bus.cp0_wen       = 1'b0;
        bus.cp0_waddr     = '0;
        bus.cp0_wdata     = '0;
        chkFlush          = 1'b0;
        pendingReads      = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clearPulses();
    endtask

    task automatic applyStimulus(input logic [31:0] pcv, input logic bd, input int ev,
                                 input logic [31:0] badAddr);
        bus.inst_valid    = 1'b1;
        bus.pc            = pcv;
        bus.in_delay_slot = bd;
        bus.if_addr_err   = (ev & EV_IFADDR) != 0;
        bus.reserved_inst = (ev & EV_RI) != 0;
        bus.overflow_err  = (ev & EV_OV) != 0;
        bus.syscall       = (ev & EV_SYS) != 0;
        bus.break_inst    = (ev & EV_BRK) != 0;
        bus.mem_addr_err  = (ev & EV_MEM) != 0;
        bus.mem_is_store  = (ev & EV_STORE) != 0;
        bus.eret          = (ev & EV_ERET) != 0;
        bus.bad_addr      = badAddr;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_wen   = 1'b1;
        bus.cp0_waddr = addr;
        bus.cp0_wdata = data;
    endtask

    task automatic expectFlush(input logic f, input logic [31:0] npc, input string name);
        flushExp_t e;
        e.flush  = f;
        e.pc     = npc;
        e.name   = name;
        chkFlush = 1'b1;
        flushQ.push_back(e);
    endtask

    task automatic checkOutput(input int src, input logic [4:0] addr, input logic [31:0] exp,
                               input string name);
        readExp_t e;
        e.src  = src;
        e.exp  = exp;
        e.name = name;
        if (src == SRC_RD) bus.cp0_raddr = addr;
        readQ.push_back(e);
        pendingReads++;
    endtask

    // Monitor: every flush the DUT raises, and every requested register view, is checked here
    always @(negedge clk) begin
        flushExp_t   fe;
        readExp_t    re;
        logic [31:0] act;
        int          n;
        if (chkFlush || bus.exc_flush === 1'b1) begin
            checks++;
            if (flushQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_flush: got flush=%b pc=%h required flush=0",
                         bus.exc_flush, bus.exc_new_pc);
            end else begin
                fe = flushQ.pop_front();
                if ((bus.exc_flush !== fe.flush) || (fe.flush && bus.exc_new_pc !== fe.pc)) begin
                    failures++;
                    $display("[TB] FAIL %s: got flush=%b pc=%h required flush=%b pc=%h",
                             fe.name, bus.exc_flush, bus.exc_new_pc, fe.flush, fe.pc);
                end
            end
        end
        n = pendingReads;
        for (int i = 0; i < n; i++) begin
            if (readQ.size() != 0) begin
                re = readQ.pop_front();
                case (re.src)
                    SRC_RD:     act = bus.cp0_rdata;
                    SRC_CAUSE:  act = bus.cause_out;
                    SRC_EPC:    act = bus.epc_out;
                    SRC_STATUS: act = bus.status_out;
                    SRC_TI:     act = {31'b0, bus.timer_int};
                    default:    act = 'x;
                endcase
                checks++;
                if (act !== re.exp) begin
                    failures++;
                    $display("[TB] FAIL %s: got %h required %h", re.name, act, re.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.pc        = '0;
        bus.hw_int    = '0;
        bus.cp0_raddr = '0;
        clearPulses();
        tick();
        tick();
        applyStimulus(32'h8000_0000, 1'b0, EV_SYS, 32'h0);
        expectFlush(1'b0, 32'h0, "flush_in_reset");
        tick();
        rst = 1'b0;

        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0000, "status_reset");
        checkOutput(SRC_CAUSE, 5'd0, 32'h0, "cause_reset");
        checkOutput(SRC_EPC, 5'd0, 32'h0, "epc_reset");
        checkOutput(SRC_TI, 5'd0, 32'h0, "timer_int_reset");
        expectFlush(1'b0, 32'h0, "no_flush_idle");
        tick();
        mtc0(5'd12, 32'h0000_FF01);
        checkOutput(SRC_RD, 5'd12, 32'h0040_0000, "status_prewrite");
        tick();
        checkOutput(SRC_RD, 5'd12, 32'h0040_FF01, "status_write");
        checkOutput(SRC_CAUSE, 5'd0, 32'h0, "cause_after_status");
        expectFlush(1'b0, 32'h0, "no_flush_after_status");
        tick();
        checkOutput(SRC_RD, 5'd8, 32'h0, "badvaddr_reset");
        mtc0(5'd12, 32'h0);
        tick();
        checkOutput(SRC_RD, 5'd11, 32'h0, "compare_reset");
        tick();

        applyStimulus(32'h8000_0100, 1'b1, EV_SYS, 32'h0);
        expectFlush(1'b1, VEC, "syscall_flush");
        tick();
        checkOutput(SRC_EPC, 5'd0, 32'h8000_00FC, "syscall_epc");
        checkOutput(SRC_CAUSE, 5'd0, 32'h8000_0020, "syscall_cause");
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0002, "syscall_exl");
        tick();
        applyStimulus(32'h8000_0104, 1'b0, EV_ERET, 32'h0);
        expectFlush(1'b1, 32'h8000_00FC, "eret_flush_1");
        tick();
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0000, "eret_exl_clear_1");
        tick();

        applyStimulus(32'h8000_0200, 1'b0, EV_OV | EV_SYS | EV_MEM | EV_STORE, 32'h1003);
        expectFlush(1'b1, VEC, "combo_flush");
        tick();
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0030, "combo_cause_ov");
        checkOutput(SRC_RD, 5'd8, 32'h0, "combo_badvaddr_kept");
        checkOutput(SRC_EPC, 5'd0, 32'h8000_0200, "combo_epc");
        tick();
        applyStimulus(32'h8000_0204, 1'b0, EV_ERET, 32'h0);
        expectFlush(1'b1, 32'h8000_0200, "eret_flush_2");
        tick();
        applyStimulus(32'h8000_0300, 1'b0, EV_MEM | EV_STORE, 32'h1003);
        expectFlush(1'b1, VEC, "ades_flush");
        tick();
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0014, "ades_cause");
        checkOutput(SRC_RD, 5'd8, 32'h0000_1003, "ades_badvaddr");
        checkOutput(SRC_EPC, 5'd0, 32'h8000_0300, "ades_epc");
        tick();

        applyStimulus(32'h8000_0400, 1'b1, EV_IFADDR | EV_ERET, 32'h0);
        mtc0(5'd14, 32'hDEAD_BEEF);
        expectFlush(1'b1, VEC, "nested_flush_beats_eret");
        tick();
        checkOutput(SRC_EPC, 5'd0, 32'h8000_0300, "nested_epc_kept");
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0010, "nested_cause");
        checkOutput(SRC_RD, 5'd8, 32'h8000_0400, "nested_badvaddr");
        tick();
        applyStimulus(32'h8000_0500, 1'b0, EV_RI | EV_BRK, 32'h0);
        expectFlush(1'b1, VEC, "ri_flush");
        tick();
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0028, "ri_over_break");
        applyStimulus(32'h8000_0504, 1'b0, EV_BRK, 32'h0);
        expectFlush(1'b1, VEC, "break_flush");
        tick();
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0024, "break_cause");
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0002, "exl_still_set");
        applyStimulus(32'h8000_0508, 1'b0, EV_ERET, 32'h0);
        expectFlush(1'b1, 32'h8000_0300, "eret_flush_3");
        tick();
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0000, "eret_exl_clear_3");

        mtc0(5'd12, 32'h0000_0401);
        tick();
        bus.hw_int = 6'b000001;
        applyStimulus(32'h8000_0600, 1'b0, 0, 32'h0);
        expectFlush(1'b0, 32'h0, "int_ip_latency");
        tick();
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0424, "ip2_latched");
        expectFlush(1'b0, 32'h0, "int_needs_inst_valid");
        tick();
        applyStimulus(32'h8000_0604, 1'b0, 0, 32'h0);
        expectFlush(1'b1, VEC, "int_flush");
        tick();
        checkOutput(SRC_CAUSE, 5'd0, 32'h0000_0400, "int_cause");
        checkOutput(SRC_EPC, 5'd0, 32'h8000_0604, "int_epc");
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0403, "int_status");
        tick();
        applyStimulus(32'h8000_0700, 1'b0, 0, 32'h0);
        expectFlush(1'b0, 32'h0, "int_masked_by_exl");
        tick();
        applyStimulus(32'h8000_0704, 1'b0, EV_ERET, 32'h0);
        bus.hw_int = '0;
        expectFlush(1'b1, 32'h8000_0604, "eret_after_int");
        tick();
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0401, "eret_status_int");
        mtc0(5'd12, 32'h0);
        tick();

        mtc0(5'd11, 32'd5);
        tick();
        mtc0(5'd9, 32'd0);
        tick();
        for (int i = 0; i < 9; i++) tick();
        checkOutput(SRC_TI, 5'd0, 32'h0, "ti_before_match");
        checkOutput(SRC_RD, 5'd9, 32'd4, "count_before_match");
        tick();
        checkOutput(SRC_TI, 5'd0, 32'h1, "ti_set");
        checkOutput(SRC_RD, 5'd9, 32'd5, "count_at_compare");
        checkOutput(SRC_CAUSE, 5'd0, 32'h4000_8000, "cause_ti_ip7");
        mtc0(5'd11, 32'd100);
        tick();
        checkOutput(SRC_TI, 5'd0, 32'h0, "ti_cleared");
        checkOutput(SRC_CAUSE, 5'd0, 32'h0, "cause_ti_cleared");
        tick();

        applyStimulus(32'h8000_0800, 1'b1, EV_SYS, 32'h0);
        expectFlush(1'b1, VEC, "pre_reset_flush");
        tick();
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0002, "pre_reset_exl");
        rst = 1'b1;
        applyStimulus(32'h8000_0804, 1'b0, EV_SYS, 32'h0);
        expectFlush(1'b0, 32'h0, "flush_gated_by_rst");
        tick();
        rst = 1'b0;
        checkOutput(SRC_STATUS, 5'd0, 32'h0040_0000, "rst_status");
        checkOutput(SRC_CAUSE, 5'd0, 32'h0, "rst_cause");
        checkOutput(SRC_EPC, 5'd0, 32'h0, "rst_epc");
        checkOutput(SRC_TI, 5'd0, 32'h0, "rst_timer_int");
        checkOutput(SRC_RD, 5'd9, 32'h0, "rst_count");
        tick();
        checkOutput(SRC_RD, 5'd8, 32'h0, "rst_badvaddr");
        tick();
        checkOutput(SRC_RD, 5'd11, 32'h0, "rst_compare");
        tick();
        tick();

        checks++;
        if (flushQ.size() != 0 || readQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d flush and %0d read entries left, required 0",
                     flushQ.size(), readQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
